// File: rtl/gamma_fix_2_2_rom_if.sv
// Address/data bundle for the gamma 2.2 lookup ROM.
// The master presents sample codes; the slave (ROM) returns corrected codes.
interface gamma_fix_2_2_rom_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output addr,
    input  rd_data
  );

  modport slave (
    input  addr,
    output rd_data
  );
endinterface

// File: rtl/gamma_fix_2_2_rom.sv
// Fixed display-gamma 2.2 ROM: rd_data = round(255 * (addr/255)^(1/2.2)).
// Registered address and registered output, always reading, full throughput.
module gamma_fix_2_2_rom #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUTPUT_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  gamma_fix_2_2_rom_if.slave     bus
);

  // Entry[a] = round-half-up(255 * (a/255)^(1/2.2)); only the 8x8 geometry is populated.
  localparam logic [DATA_WIDTH-1:0] LUT [2**ADDR_WIDTH] = '{
    8'd0,   8'd21,  8'd28,  8'd34,  8'd39,  8'd43,  8'd46,  8'd50,  8'd53,  8'd56,  8'd59,  8'd61,  8'd64,  8'd66,  8'd68,  8'd70,
    8'd72,  8'd74,  8'd76,  8'd78,  8'd80,  8'd82,  8'd84,  8'd85,  8'd87,  8'd89,  8'd90,  8'd92,  8'd93,  8'd95,  8'd96,  8'd98,
    8'd99,  8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111, 8'd112, 8'd114, 8'd115, 8'd116, 8'd117, 8'd118,
    8'd119, 8'd120, 8'd122, 8'd123, 8'd124, 8'd125, 8'd126, 8'd127, 8'd128, 8'd129, 8'd130, 8'd131, 8'd132, 8'd133, 8'd134, 8'd135,
    8'd136, 8'd137, 8'd138, 8'd139, 8'd140, 8'd141, 8'd142, 8'd143, 8'd144, 8'd144, 8'd145, 8'd146, 8'd147, 8'd148, 8'd149, 8'd150,
    8'd151, 8'd151, 8'd152, 8'd153, 8'd154, 8'd155, 8'd156, 8'd156, 8'd157, 8'd158, 8'd159, 8'd160, 8'd160, 8'd161, 8'd162, 8'd163,
    8'd164, 8'd164, 8'd165, 8'd166, 8'd167, 8'd167, 8'd168, 8'd169, 8'd170, 8'd170, 8'd171, 8'd172, 8'd173, 8'd173, 8'd174, 8'd175,
    8'd175, 8'd176, 8'd177, 8'd178, 8'd178, 8'd179, 8'd180, 8'd180, 8'd181, 8'd182, 8'd182, 8'd183, 8'd184, 8'd184, 8'd185, 8'd186,
    8'd186, 8'd187, 8'd188, 8'd188, 8'd189, 8'd190, 8'd190, 8'd191, 8'd192, 8'd192, 8'd193, 8'd194, 8'd194, 8'd195, 8'd195, 8'd196,
    8'd197, 8'd197, 8'd198, 8'd199, 8'd199, 8'd200, 8'd200, 8'd201, 8'd202, 8'd202, 8'd203, 8'd203, 8'd204, 8'd205, 8'd205, 8'd206,
    8'd206, 8'd207, 8'd207, 8'd208, 8'd209, 8'd209, 8'd210, 8'd210, 8'd211, 8'd212, 8'd212, 8'd213, 8'd213, 8'd214, 8'd214, 8'd215,
    8'd215, 8'd216, 8'd217, 8'd217, 8'd218, 8'd218, 8'd219, 8'd219, 8'd220, 8'd220, 8'd221, 8'd221, 8'd222, 8'd223, 8'd223, 8'd224,
    8'd224, 8'd225, 8'd225, 8'd226, 8'd226, 8'd227, 8'd227, 8'd228, 8'd228, 8'd229, 8'd229, 8'd230, 8'd230, 8'd231, 8'd231, 8'd232,
    8'd232, 8'd233, 8'd233, 8'd234, 8'd234, 8'd235, 8'd235, 8'd236, 8'd236, 8'd237, 8'd237, 8'd238, 8'd238, 8'd239, 8'd239, 8'd240,
    8'd240, 8'd241, 8'd241, 8'd242, 8'd242, 8'd243, 8'd243, 8'd244, 8'd244, 8'd245, 8'd245, 8'd246, 8'd246, 8'd247, 8'd247, 8'd248,
    8'd248, 8'd249, 8'd249, 8'd249, 8'd250, 8'd250, 8'd251, 8'd251, 8'd252, 8'd252, 8'd253, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255
  };

  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= bus.addr;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q <= '0;
        end else begin
          rd_q <= LUT[addr_q];
        end
      end

      assign bus.rd_data = rd_q;
    end else begin : g_comb
      assign bus.rd_data = LUT[addr_q];
    end
  endgenerate

endmodule

// File: tb/tb_gamma_fix_2_2_rom.sv
// Directed bench for gamma_fix_2_2_rom: formula-based golden values, scoreboard queue,
// reset, sweep, latency, wrap, random and asynchronous-reset sequences.
module tb_gamma_fix_2_2_rom;

  logic clk;
  logic tb_rst;

  gamma_fix_2_2_rom_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  gamma_fix_2_2_rom #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .OUTPUT_REG(1)
  ) dut (
    .clk(clk),
    .rst(tb_rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] seen[256];

  function automatic logic [7:0] gamma_ref(input int unsigned a);
    real y;
    y = 255.0 * ((real'(a) / 255.0) ** (1.0 / 2.2));
    return 8'($rtoi($floor(y + 0.5)));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive a new code after the edge, then compare the oldest in-flight result.
  task automatic cycle(input logic [7:0] v, input string tag);
    logic [7:0] exp;
    @(posedge clk);
    #1;
    bus.addr = v;
    sb.push_back(gamma_ref(int'(v)));
    @(negedge clk);
    if (sb.size() > 2) begin
      exp = sb.pop_front();
      check(tag, bus.rd_data, exp);
    end
  endtask

  task automatic rst_cycle(input string tag);
    @(posedge clk);
    #1;
    bus.addr = 8'($urandom_range(0, 255));
    @(negedge clk);
    check(tag, bus.rd_data, 8'd0);
  endtask

  // After release the output shows table[0] for one edge, then the held address.
  task automatic release_reset(input logic [7:0] held);
    bus.addr = held;
    tb_rst   = 1'b0;
    sb.delete();
    sb.push_back(8'd0);
    sb.push_back(gamma_ref(int'(held)));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tb_rst   = 1'b1;
    bus.addr = 8'd0;

    // Reset held for 200 ns with the clock running.
    for (int i = 0; i < 20; i++) rst_cycle("reset_hold");

    @(negedge clk);
    release_reset(8'd0);

    // Full sweep, two trailing cycles to drain the pipeline.
    for (int i = 0; i < 258; i++) begin
      cycle((i < 256) ? 8'(i) : 8'd0, "sweep");
      if (i >= 2) seen[i-2] = bus.rd_data;
    end
    for (int i = 1; i < 256; i++) begin
      checks++;
      assert (seen[i] >= seen[i-1]) else begin
        errors++;
        $error("FAIL mono[%0d] observed=%0d required>=%0d", i, seen[i], seen[i-1]);
      end
    end

    // Single-cycle 128 pulse between zeros.
    cycle(8'd0, "latency");
    cycle(8'd0, "latency");
    cycle(8'd128, "latency");
    for (int i = 0; i < 4; i++) cycle(8'd0, "latency");

    // Wrap 255 -> 0 back to back.
    cycle(8'd255, "wrap");
    cycle(8'd0, "wrap");
    cycle(8'd255, "wrap");
    cycle(8'd0, "wrap");
    cycle(8'd0, "wrap");
    cycle(8'd0, "wrap");

    // Random back-to-back codes.
    for (int i = 0; i < 40; i++) cycle(8'($urandom_range(0, 255)), "random");

    // Asynchronous reset between edges while the output reads 255.
    for (int i = 0; i < 3; i++) cycle(8'd255, "pre_async");
    #2;
    tb_rst = 1'b1;
    #1;
    check("async_rst", bus.rd_data, 8'd0);
    for (int i = 0; i < 3; i++) rst_cycle("async_hold");
    @(negedge clk);
    release_reset(8'd255);
    for (int i = 0; i < 4; i++) cycle(8'd255, "post_async");
    cycle(8'd64, "post_async");
    cycle(8'd1, "post_async");
    for (int i = 0; i < 3; i++) cycle(8'd0, "post_async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
